// File: rtl/mpei_gpio_pkg.sv
// Shared definitions for the APB GPIO peripheral: register offsets,
// interrupt mode encoding and a helper that trims bus words to the pin count.
package mpei_gpio_pkg;

   localparam int GPIO_DATA_IN  = 'h00;
   localparam int GPIO_DATA_OUT = 'h04;
   localparam int GPIO_OEN      = 'h08;
   localparam int GPIO_IRQ_EN   = 'h0C;
   localparam int GPIO_IRQ_MODE = 'h10;
   localparam int GPIO_IRQ_POL  = 'h14;
   localparam int GPIO_IRQ_BOTH = 'h18;
   localparam int GPIO_IRQ_PEND = 'h1C;
   localparam int GPIO_DEB_CFG  = 'h20;
   localparam int GPIO_OUT_SET  = 'h24;
   localparam int GPIO_OUT_CLR  = 'h28;

   typedef enum logic {
      IRQ_LEVEL = 1'b0,
      IRQ_EDGE  = 1'b1
   } irq_mode_e;

   function automatic logic [31:0] gpio_mask(input logic [31:0] word, input int width);
      logic [31:0] keep;
      keep = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
      return word & keep;
   endfunction

endpackage

// File: rtl/mpei_gpio_deb.sv
// One GPIO input: metastability synchroniser, debounce filter and the
// registered previous value used for edge detection.
module mpei_gpio_deb #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             din,
   input  logic [DEB_W-1:0] deb_cfg,
   output logic             d,
   output logic             rise,
   output logic             fall
);

   logic [SYNC_STAGES-1:0] sync_p0;
   logic [DEB_W-1:0]       cnt_p1;
   logic                   d_p1;
   logic                   d_prev_p2;
   logic                   s;

   assign s = sync_p0[SYNC_STAGES-1];

   // stage 0: synchroniser chain; stage 1: debounce; stage 2: previous value
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_p0   <= '0;
         cnt_p1    <= '0;
         d_p1      <= 1'b0;
         d_prev_p2 <= 1'b0;
      end else begin
         sync_p0   <= {sync_p0[SYNC_STAGES-2:0], din};
         d_prev_p2 <= d_p1;
         if (s == d_p1) begin
            cnt_p1 <= '0;
         end else if (cnt_p1 == deb_cfg) begin
            // a zero threshold matches immediately, which gives the bypass
            d_p1   <= s;
            cnt_p1 <= '0;
         end else begin
            cnt_p1 <= cnt_p1 + DEB_W'(1);
         end
      end
   end

   assign d    = d_p1;
   assign rise = d_p1 & ~d_prev_p2;
   assign fall = ~d_p1 & d_prev_p2;

endmodule

// File: rtl/mpei_apb_gpio_irq.sv
// APB GPIO peripheral: register file, atomic output set/clear, per-pin
// level/edge interrupt detection with W1C pending bits and one IRQ line.
module mpei_apb_gpio_irq
   import mpei_gpio_pkg::*;
#(
   parameter int GPIO_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 8,
   parameter int APB_AW      = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [APB_AW-1:0] paddr_i,
   input  logic [31:0]       pwdata_i,
   output logic [31:0]       prdata_o,
   output logic              pready_o,
   output logic              pslverr_o,
   input  logic [GPIO_W-1:0] gpio_in_din,
   output logic [GPIO_W-1:0] gpio_out_dout,
   output logic [GPIO_W-1:0] gpio_out_oen,
   output logic              irq_o
);

   logic              acc;
   logic              wr_en;
   logic              rd_en;
   logic              mapped;
   logic [APB_AW-1:0] addr_w;
   logic [31:0]       wmask;
   logic [GPIO_W-1:0] wdata;
   logic [31:0]       rd_word;
   logic              unused_addr_lsb;

   logic [GPIO_W-1:0] dout_q;
   logic [GPIO_W-1:0] oen_q;
   logic [GPIO_W-1:0] en_q;
   logic [GPIO_W-1:0] mode_q;
   logic [GPIO_W-1:0] pol_q;
   logic [GPIO_W-1:0] both_q;
   logic [GPIO_W-1:0] pend_q;
   logic [DEB_W-1:0]  deb_cfg_q;
   logic              irq_q;

   logic [GPIO_W-1:0] d_vec;
   logic [GPIO_W-1:0] rise_vec;
   logic [GPIO_W-1:0] fall_vec;
   logic [GPIO_W-1:0] evt;
   logic [GPIO_W-1:0] w1c;

   assign acc             = psel_i & penable_i;
   assign wr_en           = acc & pwrite_i;
   assign rd_en           = acc & ~pwrite_i;
   assign addr_w          = {paddr_i[APB_AW-1:2], 2'b00};
   assign unused_addr_lsb = ^paddr_i[1:0];
   assign wmask           = gpio_mask(pwdata_i, GPIO_W);
   assign wdata           = wmask[GPIO_W-1:0];

   for (genvar g = 0; g < GPIO_W; g++) begin : g_pin
      mpei_gpio_deb #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_W       (DEB_W)
      ) u_deb (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .din     (gpio_in_din[g]),
         .deb_cfg (deb_cfg_q),
         .d       (d_vec[g]),
         .rise    (rise_vec[g]),
         .fall    (fall_vec[g])
      );
   end

   always_comb begin
      rd_word = '0;
      mapped  = 1'b1;
      case (addr_w)
         APB_AW'(GPIO_DATA_IN):  rd_word = 32'(d_vec);
         APB_AW'(GPIO_DATA_OUT): rd_word = 32'(dout_q);
         APB_AW'(GPIO_OEN):      rd_word = 32'(oen_q);
         APB_AW'(GPIO_IRQ_EN):   rd_word = 32'(en_q);
         APB_AW'(GPIO_IRQ_MODE): rd_word = 32'(mode_q);
         APB_AW'(GPIO_IRQ_POL):  rd_word = 32'(pol_q);
         APB_AW'(GPIO_IRQ_BOTH): rd_word = 32'(both_q);
         APB_AW'(GPIO_IRQ_PEND): rd_word = 32'(pend_q);
         APB_AW'(GPIO_DEB_CFG):  rd_word = 32'(deb_cfg_q);
         APB_AW'(GPIO_OUT_SET),
         APB_AW'(GPIO_OUT_CLR):  rd_word = '0;
         default:                mapped  = 1'b0;
      endcase
   end

   assign prdata_o  = (rd_en && mapped) ? rd_word : '0;
   assign pslverr_o = acc & ~mapped;
   assign pready_o  = 1'b1;

   always_comb begin
      evt = '0;
      for (int i = 0; i < GPIO_W; i++) begin
         if (irq_mode_e'(mode_q[i]) == IRQ_EDGE) begin
            evt[i] = both_q[i] ? (rise_vec[i] | fall_vec[i])
                               : (pol_q[i] ? rise_vec[i] : fall_vec[i]);
         end else begin
            evt[i] = pol_q[i] ? d_vec[i] : ~d_vec[i];
         end
      end
   end

   assign w1c = (wr_en && addr_w == APB_AW'(GPIO_IRQ_PEND)) ? wdata : '0;

   // register stage: bus writes, pending capture and the registered IRQ line
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dout_q    <= '0;
         oen_q     <= '0;
         en_q      <= '0;
         mode_q    <= '0;
         pol_q     <= '0;
         both_q    <= '0;
         pend_q    <= '0;
         deb_cfg_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         // a new event outranks a simultaneous clear so no edge is ever lost
         pend_q <= (pend_q & ~w1c) | evt;
         irq_q  <= |(pend_q & en_q);
         if (wr_en) begin
            case (addr_w)
               APB_AW'(GPIO_DATA_OUT): dout_q    <= wdata;
               APB_AW'(GPIO_OEN):      oen_q     <= wdata;
               APB_AW'(GPIO_IRQ_EN):   en_q      <= wdata;
               APB_AW'(GPIO_IRQ_MODE): mode_q    <= wdata;
               APB_AW'(GPIO_IRQ_POL):  pol_q     <= wdata;
               APB_AW'(GPIO_IRQ_BOTH): both_q    <= wdata;
               APB_AW'(GPIO_DEB_CFG):  deb_cfg_q <= pwdata_i[DEB_W-1:0];
               APB_AW'(GPIO_OUT_SET):  dout_q    <= dout_q | wdata;
               APB_AW'(GPIO_OUT_CLR):  dout_q    <= dout_q & ~wdata;
               default: ;
            endcase
         end
      end
   end

   assign gpio_out_dout = dout_q;
   assign gpio_out_oen  = oen_q;
   assign irq_o         = irq_q;

endmodule

// File: tb/tb_mpei_apb_gpio_irq.sv
// Bench for the APB GPIO peripheral: directed scenarios plus randomized
// traffic, checked through a scoreboard fed by a behavioural model.
module tb_mpei_apb_gpio_irq;

   localparam int GW   = 8;
   localparam int SYNC = 2;
   localparam int DW   = 8;
   localparam int AW   = 8;
   localparam int MAXC = 30000;

   logic          clk = 1'b0;
   logic          rst;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [31:0]   pwdata;
   logic [31:0]   prdata;
   logic          pready, pslverr;
   logic [GW-1:0] gpio_in_din;
   logic [GW-1:0] gpio_out_dout, gpio_out_oen;
   logic          irq;

   always #5 clk = ~clk;

   mpei_apb_gpio_irq #(
      .GPIO_W(GW), .SYNC_STAGES(SYNC), .DEB_W(DW), .APB_AW(AW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable),
      .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
      .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
      .gpio_in_din(gpio_in_din), .gpio_out_dout(gpio_out_dout),
      .gpio_out_oen(gpio_out_oen), .irq_o(irq)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      int          kind;   // 0 read, 1 dout, 2 oen, 3 irq
      logic [31:0] exp;
      logic        err;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic probe  = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if ((psel && penable && !pwrite) || probe) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: output presented with no expectation queued");
         end else begin
            e = sb.pop_front();
            case (e.kind)
               0: if (prdata !== e.exp || pslverr !== e.err || pready !== 1'b1) begin
                     errors++;
                     $display("FAIL %s: got data=%h err=%b rdy=%b, expected data=%h err=%b rdy=1",
                              e.name, prdata, pslverr, pready, e.exp, e.err);
                  end
               1: if (gpio_out_dout !== e.exp[GW-1:0]) begin
                     errors++;
                     $display("FAIL %s: got dout=%h, expected %h", e.name, gpio_out_dout, e.exp[GW-1:0]);
                  end
               2: if (gpio_out_oen !== e.exp[GW-1:0]) begin
                     errors++;
                     $display("FAIL %s: got oen=%h, expected %h", e.name, gpio_out_oen, e.exp[GW-1:0]);
                  end
               default: if (irq !== e.exp[0]) begin
                     errors++;
                     $display("FAIL %s: got irq=%b, expected %b", e.name, irq, e.exp[0]);
                  end
            endcase
         end
      end
   end

   // ---------------- reference model ----------------
   // Debounced value flips once the synchronised input has disagreed with it
   // for DEB_CFG+1 consecutive samples since its last change.
   logic [GW-1:0] samp [0:MAXC];
   int            cyc;
   int            m_last [GW];
   logic [GW-1:0] m_d, m_dp, m_dout, m_oen, m_en, m_mode, m_pol, m_both, m_pend;
   logic [7:0]    m_cfg;
   logic          m_irq;

   function automatic logic [GW-1:0] s_at(input int k);
      int j;
      j = k - (SYNC - 1);
      return (j >= 1) ? samp[j] : '0;
   endfunction

   always @(posedge clk or posedge rst) begin
      logic [GW-1:0] nd, evt, w1c, sv, wv;
      logic          ok, rise, fall, irq_n;
      if (rst) begin
         cyc = 0; samp[0] = '0;
         m_d = '0; m_dp = '0; m_dout = '0; m_oen = '0; m_en = '0;
         m_mode = '0; m_pol = '0; m_both = '0; m_pend = '0; m_cfg = '0; m_irq = 1'b0;
         for (int i = 0; i < GW; i++) m_last[i] = 0;
      end else begin
         cyc++;
         samp[cyc] = gpio_in_din;
         nd = m_d;
         for (int i = 0; i < GW; i++) begin
            ok = ((cyc - 1 - int'(m_cfg)) >= m_last[i]);
            for (int k = cyc - 1 - int'(m_cfg); k <= cyc - 1; k++) begin
               sv = s_at(k);
               if (sv[i] == m_d[i]) ok = 1'b0;
            end
            if (ok) begin
               nd[i]     = ~m_d[i];
               m_last[i] = cyc;
            end
         end
         for (int i = 0; i < GW; i++) begin
            rise = m_d[i] & ~m_dp[i];
            fall = ~m_d[i] & m_dp[i];
            if (m_mode[i]) evt[i] = m_both[i] ? (rise | fall) : (m_pol[i] ? rise : fall);
            else           evt[i] = m_pol[i] ? m_d[i] : ~m_d[i];
         end
         irq_n = |(m_pend & m_en);
         w1c   = '0;
         wv    = pwdata[GW-1:0];
         if (psel && penable && pwrite) begin
            case (paddr & 8'hFC)
               8'h04: m_dout = wv;
               8'h08: m_oen  = wv;
               8'h0C: m_en   = wv;
               8'h10: m_mode = wv;
               8'h14: m_pol  = wv;
               8'h18: m_both = wv;
               8'h1C: w1c    = wv;
               8'h20: m_cfg  = pwdata[7:0];
               8'h24: m_dout = m_dout | wv;
               8'h28: m_dout = m_dout & ~wv;
               default: ;
            endcase
         end
         m_pend = (m_pend & ~w1c) | evt;
         m_dp   = m_d;
         m_d    = nd;
         m_irq  = irq_n;
      end
   end

   function automatic logic [32:0] model_read(input logic [7:0] a);
      case (a & 8'hFC)
         8'h00: return {9'h0, 16'h0, m_d};
         8'h04: return {9'h0, 16'h0, m_dout};
         8'h08: return {9'h0, 16'h0, m_oen};
         8'h0C: return {9'h0, 16'h0, m_en};
         8'h10: return {9'h0, 16'h0, m_mode};
         8'h14: return {9'h0, 16'h0, m_pol};
         8'h18: return {9'h0, 16'h0, m_both};
         8'h1C: return {9'h0, 16'h0, m_pend};
         8'h20: return {9'h0, 16'h0, m_cfg};
         8'h24, 8'h28: return 33'h0;
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   // ---------------- stimulus ----------------
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] dat);
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = dat;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, input string nm, input bit use_const,
                           input logic [31:0] cexp, input logic cerr);
      logic [32:0] m;
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
      @(posedge clk); #1 penable = 1'b1;
      m = model_read(a);
      if (use_const) sb.push_back('{0, cexp, cerr, nm});
      else           sb.push_back('{0, m[31:0], m[32], nm});
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic probe_out(input int kind, input logic [31:0] ex, input string nm);
      sb.push_back('{kind, ex, 1'b0, nm});
      probe = 1'b1;
      @(posedge clk); #1 probe = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a;
      int         r;
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; gpio_in_din = '0;
      wait_cyc(2);

      // reset state, read while reset is held so level events cannot set PEND
      probe_out(3, 0, "rst_irq");
      probe_out(1, 0, "rst_dout");
      probe_out(2, 0, "rst_oen");
      for (int i = 0; i <= 10; i++) apb_read(8'(i * 4), "rst_read", 1'b1, 32'h0, 1'b0);
      apb_read(8'h2C, "unmapped_rd", 1'b1, 32'h0, 1'b1);
      rst = 1'b0;
      wait_cyc(1);

      // data out / atomic set / clear / output enable
      apb_write(8'h04, 32'h0000_00F0);
      apb_write(8'h24, 32'h0000_000F);
      apb_write(8'h28, 32'h0000_0030);
      probe_out(1, 32'hCF, "dout_setclr");
      apb_read(8'h04, "dout_rd", 1'b1, 32'hCF, 1'b0);
      apb_read(8'h24, "outset_rd0", 1'b1, 32'h0, 1'b0);
      apb_write(8'h08, 32'h0000_00FF);
      probe_out(2, 32'hFF, "oen_ff");

      // debounce: glitch shorter than threshold is filtered
      apb_write(8'h20, 32'd4);
      gpio_in_din[0] = 1'b1;
      wait_cyc(3);
      gpio_in_din[0] = 1'b0;
      for (int i = 0; i < 6; i++) apb_read(8'h00, "deb_glitch", 1'b1, 32'h0, 1'b0);

      // debounce latency SYNC + DEB_CFG + 1 = 7 cycles
      gpio_in_din[0] = 1'b1;
      wait_cyc(5);
      apb_read(8'h00, "deb_early", 1'b1, 32'h0, 1'b0);
      apb_read(8'h00, "deb_late", 1'b1, 32'h1, 1'b0);
      gpio_in_din[0] = 1'b0;
      wait_cyc(12);
      apb_read(8'h00, "deb_low", 1'b1, 32'h0, 1'b0);
      gpio_in_din[0] = 1'b1;
      wait_cyc(6);
      apb_read(8'h00, "deb_exact", 1'b1, 32'h1, 1'b0);

      // pin3 rising-edge interrupt
      apb_write(8'h20, 32'd0);
      apb_write(8'h10, 32'hFF);
      apb_write(8'h14, 32'h08);
      apb_write(8'h18, 32'h00);
      apb_write(8'h1C, 32'hFF);
      apb_write(8'h0C, 32'h08);
      apb_read(8'h1C, "pend_clean", 1'b1, 32'h0, 1'b0);
      probe_out(3, 0, "irq_clean");
      gpio_in_din[3] = 1'b1;
      for (int i = 0; i < 8; i++) probe_out(3, {31'h0, m_irq}, "irq_latency");
      apb_read(8'h1C, "pend_rise", 1'b1, 32'h08, 1'b0);
      probe_out(3, 1, "irq_set");
      apb_write(8'h1C, 32'h08);
      wait_cyc(1);
      probe_out(3, 0, "irq_cleared");
      gpio_in_din[3] = 1'b0;
      wait_cyc(6);
      apb_read(8'h1C, "no_fall_evt", 1'b1, 32'h0, 1'b0);

      // both edges
      apb_write(8'h18, 32'h08);
      gpio_in_din[3] = 1'b1;
      wait_cyc(6);
      apb_read(8'h1C, "both_rise", 1'b1, 32'h08, 1'b0);
      apb_write(8'h1C, 32'h08);
      gpio_in_din[3] = 1'b0;
      wait_cyc(6);
      apb_read(8'h1C, "both_fall", 1'b1, 32'h08, 1'b0);
      apb_write(8'h1C, 32'h08);

      // pin5 level-low: held source re-sets after W1C
      apb_write(8'h10, 32'hDF);
      apb_write(8'h1C, 32'h20);
      apb_read(8'h1C, "lvl_reset", 1'b1, 32'h20, 1'b0);
      gpio_in_din[5] = 1'b1;
      wait_cyc(6);
      apb_write(8'h1C, 32'h20);
      apb_read(8'h1C, "lvl_gone", 1'b1, 32'h0, 1'b0);

      // W1C colliding with a rising edge on pin3 keeps the bit
      gpio_in_din[3] = 1'b1;
      wait_cyc(2);
      apb_write(8'h1C, 32'h08);
      apb_read(8'h1C, "w1c_race", 1'b1, 32'h08, 1'b0);

      // bits above GPIO_W read zero
      apb_write(8'h0C, 32'hFFFF_FFFF);
      apb_read(8'h0C, "en_mask", 1'b1, 32'h0000_00FF, 1'b0);

      // randomized traffic against the model
      for (int blk = 0; blk < 6; blk++) begin
         wait_cyc(20);
         apb_write(8'h20, 32'($urandom_range(0, 5)));
         for (int op = 0; op < 60; op++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
               gpio_in_din = gpio_in_din ^ GW'($urandom);
               wait_cyc($urandom_range(0, 6));
            end else if (r == 3) begin
               case ($urandom_range(0, 9))
                  0: a = 8'h00;  1: a = 8'h04;  2: a = 8'h08;  3: a = 8'h0C;
                  4: a = 8'h10;  5: a = 8'h14;  6: a = 8'h18;  7: a = 8'h24;
                  8: a = 8'h28;  default: a = 8'h2C;
               endcase
               apb_write(a, $urandom);
            end else if (r == 4) begin
               apb_write(8'h1C, $urandom);
            end else if (r <= 8) begin
               a = 8'($urandom_range(0, 12) * 4 + $urandom_range(0, 3));
               apb_read(a, "rand_read", 1'b0, 32'h0, 1'b0);
            end else begin
               case ($urandom_range(0, 2))
                  0: probe_out(3, {31'h0, m_irq}, "rand_irq");
                  1: probe_out(1, 32'(m_dout), "rand_dout");
                  default: probe_out(2, 32'(m_oen), "rand_oen");
               endcase
            end
         end
      end

      wait_cyc(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mpei_apb_gpio_irq.md
Name: mpei_apb_gpio_irq

Overview:
- Parametrised GPIO peripheral on the MCU APB bus: GPIO_W pins with per-pin output data, output enable, input synchroniser and programmable debounce.
- Per-pin interrupt in level or edge mode (rising, falling or both), with a W1C pending register and one combined interrupt line to the core IRQ inputs.
- Atomic set/clear of output bits, so firmware needs no read-modify-write.

Parameters:
- GPIO_W, 32, number of pins (1..32); register bits at or above GPIO_W read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser flops per pin (2..4).
- DEB_W, 8, debounce counter and DEB_CFG width (1..16).
- APB_AW, 8, APB address width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write.
- paddr_i  in  APB_AW  byte address; bits [1:0] ignored.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data.
- pready_o  out  1  always 1.
- pslverr_o  out  1  error on unmapped access.
- gpio_in_din  in  GPIO_W  asynchronous pin inputs.
- gpio_out_dout  out  GPIO_W  pin output data (DATA_OUT).
- gpio_out_oen  out  GPIO_W  1 = drive pin (OEN).
- irq_o  out  1  registered OR of (IRQ_PEND & IRQ_EN).

Behaviour:
- Reset: all registers, synchroniser flops, debounce counters, debounced value d, d_prev and irq_o are 0. pready_o = 1, prdata_o = 0, pslverr_o = 0.
- APB timing:
  - Zero wait states.
  - Write commits on the clock edge where psel_i & penable_i & pwrite_i.
  - Read: prdata_o is combinational while psel_i & penable_i & !pwrite_i, 0 otherwise.
  - Unmapped offset: pslverr_o = 1 in the access phase, read data 0, write ignored.
- Register map (offset, access):
  - 0x00 DATA_IN, RO: debounced d.
  - 0x04 DATA_OUT, RW.
  - 0x08 OEN, RW.
  - 0x0C IRQ_EN, RW.
  - 0x10 IRQ_MODE, RW: 0 = level, 1 = edge.
  - 0x14 IRQ_POL, RW: level mode 1 = high, 0 = low; edge mode 1 = rising, 0 = falling.
  - 0x18 IRQ_BOTH, RW: edge mode 1 = both edges, overrides POL.
  - 0x1C IRQ_PEND, RW1C.
  - 0x20 DEB_CFG, RW, [DEB_W-1:0].
  - 0x24 OUT_SET, WO, reads 0: DATA_OUT |= wdata.
  - 0x28 OUT_CLR, WO, reads 0: DATA_OUT &= ~wdata.
- Synchroniser: s = SYNC_STAGES-deep flop chain of gpio_in_din.
- Debounce, per pin:
  - If s == d, counter clears.
  - Otherwise counter increments; when counter == DEB_CFG, d <= s and counter clears.
  - DEB_CFG = 0 bypasses debounce: d <= s every cycle.
  - Glitch shorter than DEB_CFG cycles: counter resets and d is unchanged.
  - Latency from pin change to DATA_IN: SYNC_STAGES + DEB_CFG + 1 cycles.
  - A DEB_CFG write mid-count applies to the next comparison; the counter is not cleared.
- Event detection, d_prev <= d each cycle:
  - rise = d & ~d_prev; fall = ~d & d_prev.
  - Edge event = BOTH ? (rise | fall) : (POL ? rise : fall).
  - Level event = POL ? d : ~d, asserted every cycle the condition holds.
- IRQ_PEND:
  - Bit sets on an event regardless of IRQ_EN.
  - W1C clears it.
  - A set and a W1C clear in the same cycle leave the bit set.
  - A level source held active re-sets the bit the cycle after the clear.
- irq_o: registered, one cycle after pending or enable changes.
- Reset with a pin held high: d rises after the debounce latency and generates a rising-edge event if that mode is configured. Firmware clears IRQ_PEND after configuring.
- Reset mid-operation: immediate asynchronous return to reset values; any in-flight APB write is lost.

Decomposition:
- Package mpei_gpio_pkg:
  - Register offset localparams (GPIO_DATA_IN .. GPIO_OUT_CLR).
  - Enum irq_mode_e {IRQ_LEVEL, IRQ_EDGE}.
  - Function to mask a 32-bit word to GPIO_W.
- Sub-module mpei_gpio_deb: one pin, holding the synchroniser, debounce counter, d and d_prev, with outputs d, rise and fall. Generated GPIO_W times.
- The top level holds the APB decode, registers, pending logic and irq_o.

Test Plan:
- Reset, then read all offsets -> all 0. Read 0x2C -> pslverr_o = 1, prdata_o = 0.
- Write DATA_OUT = 0x0000_00F0, OUT_SET 0x0F, OUT_CLR 0x30 -> gpio_out_dout = 0xCF. Write OEN = 0xFF -> gpio_out_oen = 0xFF.
- DEB_CFG = 4, pin0 pulses high for 3 cycles -> DATA_IN bit0 stays 0. Pin0 held high -> bit0 = 1 exactly 2 + 4 + 1 = 7 cycles after the pin edge.
- Pin3 edge mode, POL = 1, IRQ_EN[3] = 1, pin rises -> PEND[3] = 1 and irq_o = 1 one cycle later. W1C 0x8 -> irq_o = 0. Pin falls -> no pending bit set. Then BOTH = 1 and pin toggles -> a pending bit set on each edge.
- Pin5 level-low mode with the pin held low, W1C bit5 -> PEND[5] reads 1 again the next cycle. Pin raised, then W1C -> stays 0.
- W1C on bit3 in the same cycle as a rising-edge event on pin3 -> PEND[3] remains 1. With GPIO_W = 8, write 0xFFFF_FFFF to IRQ_EN -> reads 0x0000_00FF.
